// File: rtl/kp_i2s_out.sv
// I2S output stage: attenuates and saturates each voice sample to 24 bits, then sends it on both channels of a free-running frame.
// IDLE: lines held low | RUN: frames back-to-back | DRAIN: finish the current frame, then go to IDLE
module kp_i2s_out #(
  parameter int CLK_DIV = 4
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [2:0]  attenuation,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DW-1:0]  r_div;
  logic           r_bclk;
  logic [5:0]     r_k;
  logic           r_lrclk;
  logic           r_sdata;
  logic           r_full;
  logic [31:0]    r_hold;
  logic [23:0]    r_word;
  logic           r_frame_start;
  logic           r_underrun;

  logic           w_tick;
  logic           w_fall;
  logic           w_wrap;
  logic           w_load;
  logic           w_xfer;
  logic [5:0]     w_k_nxt;
  logic [4:0]     w_k_slot;
  logic           w_bit;
  logic signed [31:0] w_shifted;
  logic [23:0]    w_sat;
  logic [23:0]    w_word_nxt;

  assign w_tick   = (r_div == DW'(CLK_DIV - 1));
  assign w_fall   = w_tick && r_bclk;
  assign w_wrap   = w_fall && (r_k == 6'd63);
  assign w_xfer   = sample_valid && !r_full;
  assign w_k_nxt  = r_k + 6'd1;
  // Both channel slots share the same position pattern inside their 32-bit half
  assign w_k_slot = w_k_nxt[4:0];
  assign w_bit    = (w_k_slot >= 5'd1 && w_k_slot <= 5'd24) ? r_word[5'd24 - w_k_slot] : 1'b0;

  assign w_shifted = $signed(r_hold) >>> attenuation;

  always_comb begin
    w_sat = w_shifted[23:0];
    if (w_shifted > 32'sd8388607) begin
      w_sat = 24'h7FFFFF;
    end else if (w_shifted < -32'sd8388608) begin
      w_sat = 24'h800000;
    end
  end

  assign w_word_nxt = mute ? 24'h000000 : (r_full ? w_sat : r_word);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_DRAIN;
        end
        if (w_wrap) begin
          w_load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (enable) begin
          w_state_nxt = S_RUN;
          w_load      = w_wrap;
        end else if (w_wrap) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_bclk        <= 1'b0;
      r_k           <= 6'd0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_full        <= 1'b0;
      r_hold        <= 32'd0;
      r_word        <= 24'd0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_full;
      if (w_load) begin
        r_word <= w_word_nxt;
      end
      if (w_load && r_full) begin
        r_full <= 1'b0;
      end else if (w_xfer) begin
        r_full <= 1'b1;
      end
      if (w_xfer) begin
        r_hold <= sample_in;
      end
      // The wrap edge that ends DRAIN naturally leaves every timing register at zero
      if (r_state == S_IDLE) begin
        r_div   <= '0;
        r_bclk  <= 1'b0;
        r_k     <= 6'd0;
        r_lrclk <= 1'b0;
        r_sdata <= 1'b0;
      end else begin
        if (w_tick) begin
          r_div  <= '0;
          r_bclk <= !r_bclk;
        end else begin
          r_div <= r_div + DW'(1);
        end
        if (w_fall) begin
          r_k     <= w_k_nxt;
          r_lrclk <= w_k_nxt[5];
          r_sdata <= w_bit;
        end
      end
    end
  end

  assign sample_ready = !r_full;
  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_kp_i2s_out.sv
// Scoreboarded bench for kp_i2s_out: the stimulus queues {underrun, word} per frame, and the monitor deserializes each frame and compares it.
module tb_kp_i2s_out;
  localparam int CD = 2;

  logic        a_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  attenuation;
  logic        mute;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;

  kp_i2s_out #(.CLK_DIV(CD)) dut (
    .a_clk(a_clk), .reset(reset), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .attenuation(attenuation), .mute(mute),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 a_clk = ~a_clk;

  int cyc = 0;
  always @(posedge a_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [24:0] sb_q[$];
  bit mon_en = 1'b1;
  int ur_stray = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per frame_start, bits captured on each bclk rise
  bit          m_coll = 1'b0;
  int          m_bits, m_ferr, m_last;
  logic [23:0] m_lw, m_rw;
  logic [24:0] m_exp;
  logic        m_pb = 1'b0;

  initial begin
    forever begin
      @(negedge a_clk);
      if (!mon_en) begin
        m_coll = 1'b0;
      end else begin
        if (underrun && !frame_start) ur_stray++;
        if (frame_start) begin
          if (m_coll) check("frame_complete", m_bits, 64);
          check("sb_has_entry", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) begin
            m_exp = sb_q.pop_front();
            check("underrun_flag", underrun, m_exp[24]);
            m_coll = 1'b1; m_bits = 0; m_ferr = 0; m_last = -1; m_lw = '0; m_rw = '0;
          end
        end
        if (m_coll && bclk && !m_pb) begin
          if (m_last >= 0 && (cyc - m_last) != 2 * CD) m_ferr++;
          m_last = cyc;
          if (lrclk !== (m_bits >= 32)) m_ferr++;
          if (m_bits >= 1 && m_bits <= 24) m_lw[24 - m_bits] = sdata;
          else if (m_bits >= 33 && m_bits <= 56) m_rw[56 - m_bits] = sdata;
          else if (sdata !== 1'b0) m_ferr++;
          m_bits++;
          if (m_bits == 64) begin
            check("left_word", m_lw, m_exp[23:0]);
            check("right_word", m_rw, m_exp[23:0]);
            check("framing", m_ferr, 0);
            m_coll = 1'b0;
          end
        end
      end
      m_pb = bclk;
    end
  end

  task automatic send(input logic [31:0] s, input logic [2:0] att, input logic mu, input logic [23:0] expw);
    int t;
    t = 0;
    @(negedge a_clk);
    while (!sample_ready && t < 2000) begin
      @(negedge a_clk);
      t++;
    end
    check("send_ready", sample_ready, 1'b1);
    sample_in = s; attenuation = att; mute = mu; sample_valid = 1'b1;
    sb_q.push_back({1'b0, expw});
    @(negedge a_clk);
    sample_valid = 1'b0;
    check("ready_low_after_xfer", sample_ready, 1'b0);
  endtask

  task automatic wait_fs(output int dt);
    dt = 0;
    do begin
      @(negedge a_clk);
      dt++;
    end while (!frame_start && dt < 600);
    if (!frame_start) check("frame_start_timeout", frame_start, 1'b1);
  endtask

  task automatic wait_falls(input int n);
    int f, t;
    logic pb;
    f = 0; t = 0; pb = bclk;
    while (f < n && t < 1000) begin
      @(negedge a_clk);
      t++;
      if (pb && !bclk) f++;
      pb = bclk;
    end
    check("bclk_falls", f, n);
  endtask

  logic [31:0] hs_s[4] = '{32'h00000001, 32'h00FEDCBA, 32'h00765432, 32'hFFF00000};
  logic [23:0] hs_e[4] = '{24'h000001, 24'h7FFFFF, 24'h765432, 24'hF00000};

  initial begin
    int dt, c0, r1, r2, hi, hx, herr, t, quiet;
    logic psd;
    reset = 1'b1; enable = 1'b0; sample_in = '0; sample_valid = 1'b0; attenuation = '0; mute = 1'b0;
    repeat (3) @(negedge a_clk);
    reset = 1'b0;
    @(negedge a_clk);
    check("rst_ready", sample_ready, 1'b1);
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);

    // Basic frame; the sample is accepted while still idle
    send(32'h00123456, 3'd0, 1'b0, 24'h123456);
    enable = 1'b1;
    wait_fs(dt);
    check("fs_at_entry", dt, 1);
    c0 = cyc;
    send(32'h00FFFFFF, 3'd0, 1'b0, 24'h7FFFFF);
    wait_fs(dt);
    check("frame_len", cyc - c0, 256);

    // Saturation and shift; the 800000 frame also gives the MSB latencies
    send(32'hFF000000, 3'd0, 1'b0, 24'h800000);
    wait_fs(dt);
    r1 = -1; r2 = -1; psd = sdata;
    for (int n = 1; n <= 200; n++) begin
      @(negedge a_clk);
      if (sdata && !psd) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      psd = sdata;
    end
    check("left_msb_latency", r1, 2 * CD);
    check("right_msb_latency", r2, 66 * CD);
    send(32'hFFFFFFF0, 3'd3, 1'b0, 24'hFFFFFE);
    send(32'h00123456, 3'd2, 1'b0, 24'h048D15);
    send(32'h80000000, 3'd7, 1'b0, 24'h800000);
    send(32'h7FFFFFFF, 3'd0, 1'b0, 24'h7FFFFF);
    send(32'h00ABCDEF, 3'd0, 1'b1, 24'h000000);

    // Handshake with valid held high
    sample_in = hs_s[0]; sample_valid = 1'b1;
    hi = 0; hx = 0; herr = 0; t = 0;
    while (hi < 4 && t < 3000) begin
      @(negedge a_clk);
      t++;
      if (frame_start) hx = 0;
      if (sample_ready) begin
        attenuation = 3'd0; mute = 1'b0;
        sb_q.push_back({1'b0, hs_e[hi]});
        hx++;
        if (hx > 1) herr++;
        hi++;
        @(negedge a_clk);
        t++;
        if (hi < 4) sample_in = hs_s[hi];
        else sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
    check("hs_transfers", hi, 4);
    check("hs_one_per_frame", herr, 0);

    // Underrun repeats the last word; muted underrun sends zeros
    send(32'h00654321, 3'd0, 1'b0, 24'h654321);
    sb_q.push_back({1'b1, 24'h654321});
    wait_fs(dt);
    wait_fs(dt);
    mute = 1'b1;
    sb_q.push_back({1'b1, 24'h000000});
    wait_fs(dt);

    // Drain: drop enable at k=10, frame completes, then silence
    send(32'h00000F0F, 3'd0, 1'b0, 24'h000F0F);
    wait_fs(dt);
    wait_falls(10);
    enable = 1'b0;
    repeat (230) @(negedge a_clk);
    quiet = 0;
    repeat (300) begin
      @(negedge a_clk);
      if (bclk || lrclk || sdata || frame_start) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // Re-raise enable during DRAIN: next frame follows without a gap
    send(32'h00234567, 3'd0, 1'b0, 24'h234567);
    enable = 1'b1;
    wait_fs(dt);
    c0 = cyc;
    send(32'h00345678, 3'd0, 1'b0, 24'h345678);
    wait_falls(20);
    enable = 1'b0;
    repeat (40) @(negedge a_clk);
    enable = 1'b1;
    wait_fs(dt);
    check("drain_no_gap", cyc - c0, 256);

    // Async reset in the right slot with a sample pending
    @(negedge a_clk);
    sample_in = 32'h01010101; sample_valid = 1'b1;
    @(negedge a_clk);
    sample_valid = 1'b0;
    wait_falls(40);
    repeat (CD) @(negedge a_clk);
    check("pre_rst_lrclk", lrclk, 1'b1);
    check("pre_rst_bclk", bclk, 1'b1);
    check("pre_rst_ready", sample_ready, 1'b0);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_bclk", bclk, 1'b0);
    check("arst_lrclk", lrclk, 1'b0);
    check("arst_sdata", sdata, 1'b0);
    check("arst_frame_start", frame_start, 1'b0);
    check("arst_underrun", underrun, 1'b0);
    enable = 1'b0;
    @(negedge a_clk);
    reset = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge a_clk);
      if (bclk || lrclk || sdata || frame_start) quiet++;
    end
    check("post_rst_ready", sample_ready, 1'b1);
    check("post_rst_quiet", quiet, 0);

    check("sb_drained", sb_q.size(), 0);
    check("stray_underrun", ur_stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
